// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator pair counter.
package ro_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    HOLD    = 3'd4
  } ro_state_t;

  // Cycles spent flushing the synchronizers before counting starts.
  localparam int RO_SETTLE_CYCLES = 3;
  // Flops in each oscillator synchronizer chain (history flop not included).
  localparam int RO_SYNC_DEPTH = 2;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizes one asynchronous oscillator line and flags its rising edges.
// Pulse appears combinationally from flopped state; no backpressure.
module ro_edge_sync
  import ro_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [RO_SYNC_DEPTH-1:0] sync_q;
  logic                     hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[RO_SYNC_DEPTH-2:0], din};
      hist_q <= sync_q[RO_SYNC_DEPTH-1];
    end
  end

  assign rise = sync_q[RO_SYNC_DEPTH-1] & ~hist_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Counts edges of one selected RO pair over WINDOW cycles and records a > b; bit_valid WINDOW+5 cycles after start.
// No backpressure: enable low aborts a measurement. Optional RO_COUNT_OUT_EN exposes captured counts.
module ro_pair_counter
  import ro_pkg::*;
#(
  parameter int NUM_PAIRS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [SEL_W-1:0]     pair_select,
  input  logic [NUM_PAIRS-1:0] ro_a,
  input  logic [NUM_PAIRS-1:0] ro_b,
  output logic                 busy,
  output logic                 bit_valid,
  output logic                 bit_out,
`ifdef RO_COUNT_OUT_EN
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b,
`endif
  output logic [NUM_PAIRS-1:0] response
);

  // One phase counter serves both the settle interval and the window.
  localparam int PH_MAX = (WINDOW > RO_SETTLE_CYCLES) ? WINDOW : RO_SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(RO_SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  ro_state_t            state;
  logic [SEL_W-1:0]     sel_q;
  logic [PH_W-1:0]      win_q;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;
  logic [NUM_PAIRS-1:0] rise_a;
  logic [NUM_PAIRS-1:0] rise_b;
  logic                 edge_a;
  logic                 edge_b;
  logic                 a_wins;

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_sync
    ro_edge_sync u_sync_a (
      .clk   (clk),
      .reset (reset),
      .din   (ro_a[g]),
      .rise  (rise_a[g])
    );
    ro_edge_sync u_sync_b (
      .clk   (clk),
      .reset (reset),
      .din   (ro_b[g]),
      .rise  (rise_b[g])
    );
  end

  assign edge_a = rise_a[sel_q];
  assign edge_b = rise_b[sel_q];
  assign a_wins = cnt_a > cnt_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      win_q     <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      busy      <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      response  <= '0;
`ifdef RO_COUNT_OUT_EN
      count_a   <= '0;
      count_b   <= '0;
`endif
    end else begin
      bit_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Out-of-range selects are ignored so no bogus response bit is written.
          if (enable && (int'(pair_select) < NUM_PAIRS)) begin
            state <= SETTLE;
            sel_q <= pair_select;
            win_q <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            busy  <= 1'b1;
          end
        end

        SETTLE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (win_q == SETTLE_LAST) begin
            state <= COUNT;
            win_q <= '0;
          end else begin
            win_q <= win_q + 1'b1;
          end
        end

        COUNT: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (edge_a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + 1'b1;
            if (edge_b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + 1'b1;
            if (win_q == WINDOW_LAST) begin
              state <= COMPARE;
              win_q <= '0;
            end else begin
              win_q <= win_q + 1'b1;
            end
          end
        end

        COMPARE: begin
          bit_out          <= a_wins;
          response[sel_q]  <= a_wins;
          bit_valid        <= 1'b1;
`ifdef RO_COUNT_OUT_EN
          count_a          <= cnt_a;
          count_b          <= cnt_b;
`endif
          state            <= HOLD;
        end

        HOLD: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Randomized plus directed bench for ro_pair_counter: main instance and a narrow-counter, 3-pair instance.
module tb_ro_pair_counter;

  localparam int W      = 16;
  localparam int LOGN   = 8192;
  localparam int CMAX_M = 65535;
  localparam int CMAX_S = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pair_select = 2'd0;
  logic [3:0] ro_a = 4'd0;
  logic [3:0] ro_b = 4'd0;

  logic       busy_m, bv_m, bo_m;
  logic [3:0] resp_m;
  logic       busy_s, bv_s, bo_s;
  logic [2:0] resp_s;
`ifdef RO_COUNT_OUT_EN
  logic [15:0] ca_m, cb_m;
  logic [2:0]  ca_s, cb_s;
`endif

  always #5 clk = ~clk;

  ro_pair_counter #(.NUM_PAIRS(4), .SEL_W(2), .CNT_W(16), .WINDOW(W)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .pair_select(pair_select),
    .ro_a(ro_a), .ro_b(ro_b), .busy(busy_m), .bit_valid(bv_m), .bit_out(bo_m),
`ifdef RO_COUNT_OUT_EN
    .count_a(ca_m), .count_b(cb_m),
`endif
    .response(resp_m)
  );

  ro_pair_counter #(.NUM_PAIRS(3), .SEL_W(2), .CNT_W(3), .WINDOW(W)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .pair_select(pair_select),
    .ro_a(ro_a[2:0]), .ro_b(ro_b[2:0]), .busy(busy_s), .bit_valid(bv_s), .bit_out(bo_s),
`ifdef RO_COUNT_OUT_EN
    .count_a(ca_s), .count_b(cb_s),
`endif
    .response(resp_s)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int bvc_m  = 0;
  int bvc_s  = 0;

  int per_a[4] = '{4, 4, 4, 4};
  int ph_a[4]  = '{0, 0, 0, 0};
  int per_b[4] = '{6, 6, 6, 6};
  int ph_b[4]  = '{0, 0, 0, 0};

  // log_x[k] = oscillator value the DUT samples at posedge number k.
  logic [3:0] log_a[0:LOGN-1];
  logic [3:0] log_b[0:LOGN-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic wave(input int per, input int ph, input int n);
    return ((n + ph) % per) < (per / 2);
  endfunction

  function automatic int rises(input bit is_b, input int p, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) begin
      logic prv, cur;
      prv = is_b ? log_b[k-1][p] : log_a[k-1][p];
      cur = is_b ? log_b[k][p]   : log_a[k][p];
      if (!prv && cur) c++;
    end
    return c;
  endfunction

  task automatic drive_ro(input int n);
    for (int p = 0; p < 4; p++) begin
      ro_a[p] = wave(per_a[p], ph_a[p], n);
      ro_b[p] = wave(per_b[p], ph_b[p], n);
    end
    if (n + 1 < LOGN) begin
      log_a[n+1] = ro_a;
      log_b[n+1] = ro_b;
    end
  endtask

  initial begin : ro_driver
    drive_ro(0);
    forever begin
      @(posedge clk);
      #1;
      drive_ro(edge_n);
    end
  end

  // Reference model: 0 idle, 1 measuring (start edge recorded), 2 holding.
  int         m_mode[2];
  int         m_st[2];
  int         m_sel[2];
  logic       m_busy[2];
  logic       m_bv[2];
  logic       m_bo[2];
  logic [3:0] m_resp[2];
  int         m_ca[2];
  int         m_cb[2];

  initial begin : model_cmp
    logic       rst_s, en_s;
    logic [1:0] sel_s;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_st[d] = 0; m_sel[d] = 0;
      m_busy[d] = 0; m_bv[d] = 0; m_bo[d] = 0; m_resp[d] = 0;
      m_ca[d] = 0; m_cb[d] = 0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      rst_s = reset;
      en_s  = enable;
      sel_s = pair_select;
      for (int d = 0; d < 2; d++) begin
        int np, cmax, el, ra, rb;
        np   = (d == 0) ? 4 : 3;
        cmax = (d == 0) ? CMAX_M : CMAX_S;
        m_bv[d] = 1'b0;
        if (rst_s) begin
          m_mode[d] = 0; m_bo[d] = 0; m_resp[d] = 0; m_ca[d] = 0; m_cb[d] = 0;
        end else if (m_mode[d] == 0) begin
          if (en_s && int'(sel_s) < np) begin
            m_mode[d] = 1; m_st[d] = edge_n; m_sel[d] = int'(sel_s);
          end
        end else if (m_mode[d] == 1) begin
          el = edge_n - m_st[d];
          if (el == W + 4) begin
            // Counted window: rising transitions between samples start+2 .. start+W+1.
            ra = rises(1'b0, m_sel[d], m_st[d] + 2, m_st[d] + W + 1);
            rb = rises(1'b1, m_sel[d], m_st[d] + 2, m_st[d] + W + 1);
            m_ca[d] = (ra > cmax) ? cmax : ra;
            m_cb[d] = (rb > cmax) ? cmax : rb;
            m_bo[d] = m_ca[d] > m_cb[d];
            m_resp[d][m_sel[d]] = m_bo[d];
            m_bv[d] = 1'b1;
            m_mode[d] = 2;
          end else if (!en_s) begin
            m_mode[d] = 0;
          end
        end else begin
          if (!en_s) m_mode[d] = 0;
        end
        m_busy[d] = (m_mode[d] != 0);
      end
      #2;
      chk("busy_m", 32'(busy_m), 32'(m_busy[0]));
      chk("bit_valid_m", 32'(bv_m), 32'(m_bv[0]));
      chk("bit_out_m", 32'(bo_m), 32'(m_bo[0]));
      chk("response_m", 32'(resp_m), 32'(m_resp[0]));
      chk("busy_s", 32'(busy_s), 32'(m_busy[1]));
      chk("bit_valid_s", 32'(bv_s), 32'(m_bv[1]));
      chk("bit_out_s", 32'(bo_s), 32'(m_bo[1]));
      chk("response_s", 32'(resp_s), 32'(m_resp[1][2:0]));
`ifdef RO_COUNT_OUT_EN
      chk("count_a_m", 32'(ca_m), 32'(m_ca[0]));
      chk("count_b_m", 32'(cb_m), 32'(m_cb[0]));
      chk("count_a_s", 32'(ca_s), 32'(m_ca[1]));
      chk("count_b_s", 32'(cb_s), 32'(m_cb[1]));
`endif
      if (bv_m) bvc_m++;
      if (bv_s) bvc_s++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input int p, input int pa, input int pha, input int pb, input int phb);
    per_a[p] = pa; ph_a[p] = pha; per_b[p] = pb; ph_b[p] = phb;
  endtask

  task automatic measure(input int sel, output int lat);
    int e0;
    enable      = 1'b1;
    pair_select = 2'(sel);
    e0  = edge_n + 1;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bv_m || bv_s) begin
        lat = edge_n - e0 + 1;
        break;
      end
    end
    enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, b0, s0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy_m), 32'd0);
    chk("reset_bit_out", 32'(bo_m), 32'd0);
    chk("reset_response", 32'(resp_m), 32'd0);
    reset = 1'b0;
    tick();

    // Clean measurement on pair 2: A period 4 beats B period 6.
    set_pair(2, 4, 0, 6, 0);
    b0 = bvc_m;
    measure(2, lat);
    chk("clean_latency", 32'(lat), 32'd21);
    chk("clean_bit_out", 32'(bo_m), 32'd1);
    chk("clean_response", 32'(resp_m), 32'b0100);
    chk("clean_pulses", 32'(bvc_m - b0), 32'd1);

    // Tie on pair 0.
    set_pair(0, 5, 1, 5, 1);
    b0 = bvc_m;
    measure(0, lat);
    chk("tie_bit_out", 32'(bo_m), 32'd0);
    chk("tie_response", 32'(resp_m), 32'b0100);
    chk("tie_pulses", 32'(bvc_m - b0), 32'd1);

    // Full sequence: A slower on pairs 1 and 3.
    set_pair(0, 4, 0, 7, 0);
    set_pair(1, 7, 0, 3, 0);
    set_pair(2, 3, 0, 8, 0);
    set_pair(3, 9, 0, 4, 0);
    b0 = bvc_m;
    s0 = bvc_s;
    for (int p = 0; p < 4; p++) measure(p, lat);
    chk("seq_response", 32'(resp_m), 32'b0101);
    chk("seq_pulses", 32'(bvc_m - b0), 32'd4);
    chk("seq_pulses_narrow", 32'(bvc_s - s0), 32'd3);

    // Abort on the 8th COUNT cycle of pair 1.
    set_pair(1, 3, 0, 9, 0);
    b0 = bvc_m;
    enable = 1'b1;
    pair_select = 2'd1;
    repeat (11) tick();
    enable = 1'b0;
    tick();
    chk("abort_busy", 32'(busy_m), 32'd0);
    tick();
    chk("abort_response", 32'(resp_m), 32'b0101);
    chk("abort_pulses", 32'(bvc_m - b0), 32'd0);
    measure(1, lat);
    chk("restart_response", 32'(resp_m), 32'b0111);

    // Reset mid-COUNT.
    enable = 1'b1;
    pair_select = 2'd2;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("midreset_busy", 32'(busy_m), 32'd0);
    chk("midreset_bit_out", 32'(bo_m), 32'd0);
    chk("midreset_response", 32'(resp_m), 32'd0);
    chk("midreset_bit_valid", 32'(bv_m), 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // Saturation: A period 2 gives 8 edges, which the 3-bit instance holds at 7.
    set_pair(1, 2, 0, 3, 0);
    measure(1, lat);
    chk("sat_bit_out_narrow", 32'(bo_s), 32'd1);
    chk("sat_bit_out_main", 32'(bo_m), 32'd1);
`ifdef RO_COUNT_OUT_EN
    chk("sat_count_a_narrow", 32'(ca_s), 32'd7);
    chk("sat_count_a_main", 32'(ca_m), 32'd8);
`endif

    // Randomized sessions with aborts, resets and select changes mid-measurement.
    for (int it = 0; it < 50; it++) begin
      int hold;
      for (int p = 0; p < 4; p++) begin
        int pa, pb;
        pa = $urandom_range(2, 10);
        pb = $urandom_range(2, 10);
        set_pair(p, pa, $urandom_range(0, pa - 1), pb, $urandom_range(0, pb - 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      enable = 1'b1;
      pair_select = 2'($urandom_range(0, 3));
      hold = $urandom_range(2, 30);
      for (int c = 0; c < hold; c++) begin
        tick();
        if ($urandom_range(0, 7) == 0) pair_select = 2'($urandom_range(0, 3));
      end
      enable = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
